mem_access: RTL and testbench
=============================

# mem_access

MEM-stage data-memory access unit of the MIPS32 pipeline. It sits after the EX/MEM pipeline register and consumes that register's outputs: destination address, write enable, ALU result, memory op, effective address and store data. It performs loads and stores over a req/ack data bus and delivers registered writeback values toward MEM/WB. While a bus transaction is outstanding it raises a stall request.

## Interface
- No parameters. Widths: `RegBus` = 32, `RegAddrBus` = 5.
- Clock and reset: one clock; reset is synchronous and active-high. Ports `clk` and `rst`, asserted when `rst == RstEnable`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_dest_addr  in  5  destination register from EX/MEM
- mem_wreg  in  1  register write enable from EX/MEM
- mem_dest_data  in  32  ALU result from EX/MEM
- mem_op  in  4  memory op: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9–15 are treated as NONE
- mem_addr  in  32  effective address
- mem_store_data  in  32  rt value to store
- bus_rdata  in  32  read data, valid in the ack cycle
- bus_ack  in  1  transaction complete
- bus_req  out  1  request (registered)
- bus_we  out  1  1 = write (registered)
- bus_addr  out  32  word address, `{mem_addr[31:2],2'b00}` (registered)
- bus_sel  out  4  byte-lane enables; bit 3 = bits 31:24 (registered)
- bus_wdata  out  32  write data (registered)
- wb_dest_addr  out  5  to MEM/WB (registered)
- wb_wreg  out  1  to MEM/WB (registered)
- wb_dest_data  out  32  to MEM/WB (registered)
- stallreq  out  1  combinational; hold upstream stages
- exc_misalign  out  1  one-cycle pulse on an unaligned access (registered)
- exc_badaddr  out  32  offending address (registered; holds its value until the next misalignment)

## Operation
- Reset values: state IDLE; bus_req 0; bus_we 0; bus_addr, bus_wdata, wb_dest_data, exc_badaddr = ZeroWord; bus_sel 0; wb_dest_addr = NOPRegAddr; wb_wreg = False; exc_misalign 0.
- Reset asserted mid-transaction: return to IDLE and drop bus_req next edge. Any late bus_ack is ignored.
- The state machine has two states, IDLE and BUSY.
- **IDLE, op NONE:** wb_* <= mem_dest_addr/mem_wreg/mem_dest_data. stallreq 0.
- **IDLE, op is a load or store and the address is aligned:**
  - stallreq 1.
  - Next edge: bus_req 1, bus_we = store, bus_addr/bus_sel/bus_wdata set, wb_wreg <= 0 (bubble), go to BUSY.
- **IDLE, misaligned access:**
  - Misaligned means a halfword op with addr[0]=1, or a word op with addr[1:0]≠0.
  - No bus access and stallreq 0.
  - Next edge: exc_misalign 1, exc_badaddr <= mem_addr, wb_wreg <= 0.
- **BUSY, bus_ack 0:** stallreq 1; bus outputs hold; wb_wreg 0.
- **BUSY, bus_ack 1:**
  - stallreq 0.
  - Next edge: bus_req 0, go to IDLE.
  - Load: wb_dest_addr <= mem_dest_addr, wb_wreg <= mem_wreg, wb_dest_data <= extended load data.
  - Store: wb_wreg <= 0.
- Lane selection is big-endian, by addr[1:0]:
  - Byte: 0→1000 (bits 31:24), 1→0100, 2→0010, 3→0001.
  - Halfword: 0→1100, 2→0011.
  - Word: 1111.
- Load extension: LB/LH sign-extend the selected lane; LBU/LHU zero-extend it; LW passes the word through.
- Store data is replicated: SB → `{4{rt[7:0]}}`, SH → `{2{rt[15:0]}}`, SW → rt.
- Upstream holds mem_* stable while stallreq=1. The unit samples them only in IDLE and in the ack cycle.

## Timing
- Non-memory op: 1-cycle latency to wb_*, no stall.
- Memory op with ack in the first BUSY cycle: issue cycle T0 (stallreq 1), T1 bus_req 1 and ack (stallreq 0), T2 wb_* valid and bus_req 0. This gives exactly one stall cycle.
- Each extra wait cycle adds one stall cycle.
- bus_rdata is sampled only on the clk edge that ends the ack cycle.
- bus_ack in IDLE is ignored.
- Back-to-back memory ops: the second op enters at T2 in IDLE and issues a fresh request. bus_req is low for at least one cycle between transactions.
- stallreq never depends on bus_rdata.

## Test plan
- Reset, then op NONE, dest 5, wreg 1, data 0x1234 → next cycle wb_dest_addr 5, wb_wreg 1, wb_dest_data 0x00001234, stallreq never high.
- LB at addr 0x103 with bus_rdata 0x000000F0, ack after 2 wait cycles:
  - bus_addr 0x100, bus_sel 0001.
  - stallreq high for 3 cycles.
  - wb_dest_data 0xFFFFFFF0.
  - LBU of the same data → 0x000000F0.
- SH at 0x202, rt 0xCAFEBEEF, immediate ack → bus_we 1, bus_sel 0011, bus_wdata 0xBEEFBEEF, wb_wreg 0, one stall cycle.
- LW at 0x301 → no bus_req, stallreq 0, exc_misalign pulses one cycle, exc_badaddr 0x301, wb_wreg 0. LH at 0x302 proceeds normally with bus_sel 0011.
- rst asserted in BUSY before ack → next cycle bus_req 0, state IDLE, wb_* at reset values. A later stray ack produces no writeback.
- LW then SW back-to-back with immediate acks → two distinct bus_req pulses separated by a low cycle. The load writes back 0xDEADBEEF before the store completes.

Source files
------------

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: issues loads/stores on a req/ack bus,
// formats lanes big-endian, and registers the writeback toward MEM/WB.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_dest_addr,
    input  logic        mem_wreg,
    input  logic [31:0] mem_dest_data,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic [4:0]  wb_dest_addr,
    output logic        wb_wreg,
    output logic [31:0] wb_dest_data,
    output logic        stallreq,
    output logic        exc_misalign,
    output logic [31:0] exc_badaddr
);

    localparam logic        RstEnable  = 1'b1;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;
    localparam logic        False      = 1'b0;

    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLbu = 4'd2;
    localparam logic [3:0] OpLh  = 4'd3;
    localparam logic [3:0] OpLhu = 4'd4;
    localparam logic [3:0] OpLw  = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;

    typedef enum logic {StIdle, StBusy} state_t;
    state_t state;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        misalign;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Decode the op: class, alignment, lane enables, store data and load result.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        sel_c    = 4'b0000;
        wdata_c  = mem_store_data;
        load_c   = bus_rdata;

        case (mem_addr[1:0])
            2'd0:    rd_byte = bus_rdata[31:24];
            2'd1:    rd_byte = bus_rdata[23:16];
            2'd2:    rd_byte = bus_rdata[15:8];
            default: rd_byte = bus_rdata[7:0];
        endcase
        rd_half = mem_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];

        case (mem_op)
            OpLb, OpLbu, OpSb: begin
                is_load  = (mem_op != OpSb);
                is_store = (mem_op == OpSb);
                case (mem_addr[1:0])
                    2'd0:    sel_c = 4'b1000;
                    2'd1:    sel_c = 4'b0100;
                    2'd2:    sel_c = 4'b0010;
                    default: sel_c = 4'b0001;
                endcase
                wdata_c = {4{mem_store_data[7:0]}};
                load_c  = (mem_op == OpLb) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            end
            OpLh, OpLhu, OpSh: begin
                is_load  = (mem_op != OpSh);
                is_store = (mem_op == OpSh);
                misalign = mem_addr[0];
                sel_c    = mem_addr[1] ? 4'b0011 : 4'b1100;
                wdata_c  = {2{mem_store_data[15:0]}};
                load_c   = (mem_op == OpLh) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            end
            OpLw, OpSw: begin
                is_load  = (mem_op == OpLw);
                is_store = (mem_op == OpSw);
                misalign = (mem_addr[1:0] != 2'b00);
                sel_c    = 4'b1111;
                wdata_c  = mem_store_data;
                load_c   = bus_rdata;
            end
            default: ;
        endcase
        is_mem = is_load | is_store;
    end

    // Hold upstream while an aligned access is issuing or the bus has not yet acked.
    always_comb begin
        stallreq = 1'b0;
        case (state)
            StIdle:  stallreq = is_mem & ~misalign;
            StBusy:  stallreq = ~bus_ack;
            default: stallreq = 1'b0;
        endcase
    end

    // Two-state access FSM with all bus, writeback and exception outputs registered.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state        <= StIdle;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= ZeroWord;
            bus_sel      <= 4'b0000;
            bus_wdata    <= ZeroWord;
            wb_dest_addr <= NOPRegAddr;
            wb_wreg      <= False;
            wb_dest_data <= ZeroWord;
            exc_misalign <= 1'b0;
            exc_badaddr  <= ZeroWord;
        end else begin
            exc_misalign <= 1'b0;
            case (state)
                StIdle: begin
                    if (!is_mem) begin
                        wb_dest_addr <= mem_dest_addr;
                        wb_wreg      <= mem_wreg;
                        wb_dest_data <= mem_dest_data;
                    end else if (misalign) begin
                        exc_misalign <= 1'b1;
                        exc_badaddr  <= mem_addr;
                        wb_wreg      <= False;
                    end else begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_sel   <= sel_c;
                        bus_wdata <= wdata_c;
                        wb_wreg   <= False;
                        state     <= StBusy;
                    end
                end
                StBusy: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= StIdle;
                        if (is_load) begin
                            wb_dest_addr <= mem_dest_addr;
                            wb_wreg      <= mem_wreg;
                            wb_dest_data <= load_c;
                        end else begin
                            wb_wreg <= False;
                        end
                    end else begin
                        wb_wreg <= False;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases followed by random ops
// checked against a lane-arithmetic reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_dest_addr;
    logic        mem_wreg;
    logic [31:0] mem_dest_data;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_store_data;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [4:0]  wb_dest_addr;
    logic        wb_wreg;
    logic [31:0] wb_dest_data;
    logic        stallreq;
    logic        exc_misalign;
    logic [31:0] exc_badaddr;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected MEM/WB contents, maintained by the model.
    logic [4:0]  exp_wb_addr;
    logic        exp_wb_wreg;
    logic [31:0] exp_wb_data;

    mem_access dut (
        .clk            (clk),
        .rst            (rst),
        .mem_dest_addr  (mem_dest_addr),
        .mem_wreg       (mem_wreg),
        .mem_dest_data  (mem_dest_data),
        .mem_op         (mem_op),
        .mem_addr       (mem_addr),
        .mem_store_data (mem_store_data),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_sel        (bus_sel),
        .bus_wdata      (bus_wdata),
        .wb_dest_addr   (wb_dest_addr),
        .wb_wreg        (wb_wreg),
        .wb_dest_data   (wb_dest_data),
        .stallreq       (stallreq),
        .exc_misalign   (exc_misalign),
        .exc_badaddr    (exc_badaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model helpers, computed from byte positions with plain arithmetic.
    function automatic int op_size(input logic [3:0] op);
        if (op == 1 || op == 2 || op == 6) return 1;
        if (op == 3 || op == 4 || op == 7) return 2;
        if (op == 5 || op == 8) return 4;
        return 0;
    endfunction

    function automatic logic [3:0] model_sel(input logic [3:0] op, input logic [31:0] a);
        int sz = op_size(op);
        int off = int'(a % 4);
        // Lane index 0 is bits 31:24 (sel bit 3); an access covers lanes off..off+sz-1.
        int s = 0;
        for (int k = 0; k < sz; k++) s += 8 >> (off + k);
        return 4'(s);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] rt);
        int sz = op_size(op);
        if (sz == 1) return (rt % 256) * 32'h0101_0101;
        if (sz == 2) return (rt % 65536) * 32'h0001_0001;
        return rt;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] w);
        int sz = op_size(op);
        int off = int'(a % 4);
        longint v;
        if (sz == 4) return w;
        v = longint'((w >> (8 * (4 - off - sz))) % (32'd1 << (8 * sz)));
        if ((op == 1 || op == 3) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    task automatic check_wb(input string tag);
        check({tag, ".wb_dest_addr"}, 32'(wb_dest_addr), 32'(exp_wb_addr));
        check({tag, ".wb_wreg"}, 32'(wb_wreg), 32'(exp_wb_wreg));
        check({tag, ".wb_dest_data"}, wb_dest_data, exp_wb_data);
    endtask

    // Present one op at the current cycle (just after a rising edge) and run it to completion.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] dest, input logic wreg,
                          input logic [31:0] data, input logic [31:0] rdata, input int waits);
        int sz;
        bit mis;
        bit is_store;
        int stalls;
        sz = op_size(op);
        mis = (sz > 1) && (addr % sz != 0);
        is_store = (op >= 6 && op <= 8);
        mem_op = op;
        mem_addr = addr;
        mem_store_data = sdata;
        mem_dest_addr = dest;
        mem_wreg = wreg;
        mem_dest_data = data;
        bus_ack = 1'b0;
        #1;
        if (sz == 0) begin
            check({tag, ".stall"}, 32'(stallreq), 0);
            @(posedge clk); #1;
            exp_wb_addr = dest;
            exp_wb_wreg = wreg;
            exp_wb_data = data;
            check_wb(tag);
            check({tag, ".bus_req"}, 32'(bus_req), 0);
            check({tag, ".exc"}, 32'(exc_misalign), 0);
        end else if (mis) begin
            check({tag, ".stall"}, 32'(stallreq), 0);
            @(posedge clk); #1;
            exp_wb_wreg = 1'b0;
            check({tag, ".exc"}, 32'(exc_misalign), 1);
            check({tag, ".badaddr"}, exc_badaddr, addr);
            check({tag, ".bus_req"}, 32'(bus_req), 0);
            check_wb(tag);
            mem_op = 4'd0;
            mem_wreg = 1'b0;
            mem_dest_addr = 5'd0;
            mem_dest_data = 32'd0;
            @(posedge clk); #1;
            exp_wb_addr = 5'd0;
            exp_wb_data = 32'd0;
            check({tag, ".exc_pulse"}, 32'(exc_misalign), 0);
            check({tag, ".badaddr_hold"}, exc_badaddr, addr);
        end else begin
            stalls = int'(stallreq);
            @(posedge clk); #1;
            check({tag, ".bus_req"}, 32'(bus_req), 1);
            check({tag, ".bus_we"}, 32'(bus_we), 32'(is_store));
            check({tag, ".bus_addr"}, bus_addr, addr - (addr % 4));
            check({tag, ".bus_sel"}, 32'(bus_sel), 32'(model_sel(op, addr)));
            if (is_store) check({tag, ".bus_wdata"}, bus_wdata, model_wdata(op, sdata));
            check({tag, ".wb_wreg_bubble"}, 32'(wb_wreg), 0);
            for (int i = 0; i < waits; i++) begin
                stalls += int'(stallreq);
                @(posedge clk); #1;
                check({tag, ".bus_req_hold"}, 32'(bus_req), 1);
            end
            bus_ack = 1'b1;
            bus_rdata = rdata;
            #1;
            stalls += int'(stallreq);
            check({tag, ".stall_count"}, 32'(stalls), 32'(waits + 1));
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (is_store) begin
                exp_wb_wreg = 1'b0;
            end else begin
                exp_wb_addr = dest;
                exp_wb_wreg = wreg;
                exp_wb_data = model_load(op, addr, rdata);
            end
            check({tag, ".bus_req_drop"}, 32'(bus_req), 0);
            check_wb(tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_dest_addr = '0;
        mem_wreg = 1'b0;
        mem_dest_data = '0;
        mem_op = '0;
        mem_addr = '0;
        mem_store_data = '0;
        bus_rdata = '0;
        bus_ack = 1'b0;
        exp_wb_addr = '0;
        exp_wb_wreg = 1'b0;
        exp_wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.bus_req", 32'(bus_req), 0);
        check("reset.bus_sel", 32'(bus_sel), 0);
        check("reset.bus_addr", bus_addr, 0);
        check("reset.exc", 32'(exc_misalign), 0);
        check("reset.badaddr", exc_badaddr, 0);
        check_wb("reset");
        rst = 1'b0;

        // Directed cases.
        run_op("none", 4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 0);
        run_op("lb", 4'd1, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 32'h0000_00F0, 2);
        check("lb.value", wb_dest_data, 32'hFFFF_FFF0);
        run_op("lbu", 4'd2, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 32'h0000_00F0, 2);
        check("lbu.value", wb_dest_data, 32'h0000_00F0);
        run_op("sh", 4'd7, 32'h202, 32'hCAFE_BEEF, 5'd3, 1'b1, 32'h0, 32'h0, 0);
        check("sh.wdata", bus_wdata, 32'hBEEF_BEEF);
        run_op("lw_mis", 4'd5, 32'h301, 32'h0, 5'd4, 1'b1, 32'h0, 32'h0, 0);
        run_op("lh", 4'd3, 32'h302, 32'h0, 5'd4, 1'b1, 32'h0, 32'h1234_8001, 1);

        // Reset while the bus is still waiting.
        mem_op = 4'd5;
        mem_addr = 32'h400;
        mem_dest_addr = 5'd9;
        mem_wreg = 1'b1;
        @(posedge clk); #1;
        check("rstbusy.bus_req", 32'(bus_req), 1);
        rst = 1'b1;
        mem_op = 4'd0;
        mem_wreg = 1'b0;
        mem_dest_addr = 5'd0;
        mem_dest_data = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_wb_addr = '0;
        exp_wb_wreg = 1'b0;
        exp_wb_data = '0;
        check("rstbusy.bus_req_drop", 32'(bus_req), 0);
        check("rstbusy.stall", 32'(stallreq), 0);
        check_wb("rstbusy");
        bus_ack = 1'b1;
        bus_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check("stray_ack.bus_req", 32'(bus_req), 0);
        check_wb("stray_ack");

        // Back-to-back load then store.
        run_op("b2b_lw", 4'd5, 32'h500, 32'h0, 5'd10, 1'b1, 32'h0, 32'hDEAD_BEEF, 0);
        check("b2b_lw.value", wb_dest_data, 32'hDEAD_BEEF);
        run_op("b2b_sw", 4'd8, 32'h504, 32'h1357_9BDF, 5'd11, 1'b1, 32'h0, 32'h0, 0);

        // Random ops, including undefined codes and misaligned addresses.
        for (int n = 0; n < 60; n++) begin
            run_op("rand", 4'($urandom_range(0, 15)), $urandom, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
